// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//
// Buffered UART transmitter with a fixed 8N2 frame:
//   start bit (0), 8 data bits LSB first, 2 stop bits (1), no parity.
// Bytes are queued in a small FIFO and sent one after another. While a
// frame is on the line, baud_en keeps an external baud tick generator
// running, and every baud_tick moves the line to the next bit period.
//
// Parameters
//   FifoDepth  : transmit FIFO depth, a power of two from 2 to 16
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : synchronous active-high reset; aborts any frame and
//                empties the FIFO
//   tx_valid   : write request
//   tx_data    : byte to queue for transmission
//   tx_ready   : FIFO can accept a write (decoded from the registered count)
//   baud_tick  : one-cycle bit-period tick, honoured only while baud_en=1
//   baud_en    : enable for the baud tick generator (registered)
//   txd        : serial line, idle high (registered)
//   tx_busy    : a frame is in progress (registered)
//   fifo_count : number of queued bytes, not counting the byte being sent

module uart_tx_sched #(
    parameter int FifoDepth = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tx_valid,
    input  logic [7:0]                   tx_data,
    output logic                         tx_ready,
    input  logic                         baud_tick,
    output logic                         baud_en,
    output logic                         txd,
    output logic                         tx_busy,
    output logic [$clog2(FifoDepth):0]   fifo_count
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP1,
        STOP2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_next;
    logic [7:0]      shift;
    logic [7:0]      shift_next;
    logic            txd_next;
    logic            baud_en_next;
    logic            tx_busy_next;

    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;

    logic            push;
    logic            pop;
    logic            tick;
    logic            fifo_empty;

    // Readiness comes only from the registered count, so a write offered
    // while full is refused even if a pop happens on the same edge.
    assign tx_ready   = (fifo_count != CntW'(FifoDepth));
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (fifo_count == '0);

    // Ticks that arrive while the generator is disabled are stray and ignored.
    assign tick       = baud_tick && baud_en;

    // FIFO bookkeeping. FifoDepth is a power of two, so the pointers wrap
    // naturally at their full width. A pop needs a non-empty FIFO, so a
    // same-edge push always lands behind the entry being popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CntW'(1);
                2'b01:   fifo_count <= fifo_count - CntW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage has no reset; stale contents are never read because the
    // count gates every pop.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Frame sequencer state and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
            baud_en <= 1'b0;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            txd     <= txd_next;
            baud_en <= baud_en_next;
            tx_busy <= tx_busy_next;
        end
    end

    // Next-state logic. The line value for each bit period is computed
    // here and registered, so txd never glitches. Leaving STOP2 with more
    // data queued goes straight back to START with baud_en held high, which
    // keeps the tick phase continuous between frames.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        txd_next     = txd;
        baud_en_next = baud_en;
        tx_busy_next = tx_busy;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                txd_next     = 1'b1;
                baud_en_next = 1'b0;
                tx_busy_next = 1'b0;
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = mem[rd_ptr];
                    state_next   = START;
                    txd_next     = 1'b0;
                    baud_en_next = 1'b1;
                    tx_busy_next = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    txd_next     = shift[0];
                end
            end

            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP1;
                        txd_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        txd_next     = shift[bit_idx + 3'd1];
                    end
                end
            end

            STOP1: begin
                if (tick) begin
                    state_next = STOP2;
                    txd_next   = 1'b1;
                end
            end

            STOP2: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next   = IDLE;
                        txd_next     = 1'b1;
                        baud_en_next = 1'b0;
                        tx_busy_next = 1'b0;
                    end
                end
            end

            default: begin
                state_next   = IDLE;
                txd_next     = 1'b1;
                baud_en_next = 1'b0;
                tx_busy_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
//
// Self-checking bench for uart_tx_sched (FifoDepth=4). A transaction-level
// reference model (a byte queue plus "ticks left in the current 11-tick
// frame") predicts txd, baud_en, tx_busy, tx_ready and fifo_count each cycle.
// Scenario tasks drive directed and randomized stimulus and compare inline.

module tb_uart_tx_sched;

    localparam int Depth = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          baud_tick;
    logic          baud_en;
    logic          txd;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_busy  = 1'b0;
    logic [7:0] m_cur   = '0;
    int         m_left  = 0;
    bit         m_pushed = 1'b0;

    // Line values captured on each honoured tick (one per bit period)
    logic       tick_bits[$];

    uart_tx_sched #(.FifoDepth(Depth)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .baud_tick  (baud_tick),
        .baud_en    (baud_en),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Whole frame as 11 bits, bit 0 sent first
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {2'b11, b, 1'b0};
    endfunction

    // Expected {txd, baud_en, tx_busy, tx_ready, fifo_count}
    function automatic logic [6:0] model_vec();
        logic       exp_txd;
        logic [10:0] f;
        exp_txd = 1'b1;
        if (m_busy) begin
            f       = frame_of(m_cur);
            exp_txd = f[11 - m_left];
        end
        return {exp_txd, m_busy, m_busy, (mq.size() != Depth), CW'(mq.size())};
    endfunction

    // Advance one clock edge and the reference model; returns 1 ns after it.
    task automatic step();
        bit do_push;
        if (baud_tick && m_busy) tick_bits.push_back(txd);
        @(posedge clk);
        m_pushed = 1'b0;
        if (rst) begin
            mq.delete();
            m_busy = 1'b0;
            m_left = 0;
        end else begin
            do_push = tx_valid && (mq.size() != Depth);
            if (!m_busy) begin
                if (mq.size() > 0) begin
                    m_cur  = mq.pop_front();
                    m_busy = 1'b1;
                    m_left = 11;
                end
            end else if (baud_tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (mq.size() > 0) begin
                        m_cur  = mq.pop_front();
                        m_left = 11;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end
            if (do_push) begin
                mq.push_back(tx_data);
                m_pushed = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF; baud_tick = 1'b1;
        step();
        step();
        n_checks++;
        if ({txd, baud_en, tx_busy, tx_ready, fifo_count} !== 7'b1001000) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %b expected %b",
                     {txd, baud_en, tx_busy, tx_ready, fifo_count}, 7'b1001000);
        end
        rst = 1'b0; tx_valid = 1'b0; baud_tick = 1'b0;
        step();
        n_checks++;
        if ({txd, baud_en, tx_busy, tx_ready, fifo_count} !== 7'b1001000) begin
            n_fail++;
            $display("[TB] FAIL reset_no_write: got %b expected %b",
                     {txd, baud_en, tx_busy, tx_ready, fifo_count}, 7'b1001000);
        end
    endtask

    task automatic test_single_byte();
        logic [10:0] exp_bits = 11'b11101001010;
        logic [10:0] got;
        tick_bits.delete();
        tx_valid = 1'b1; tx_data = 8'hA5;
        step();
        tx_valid = 1'b0;
        step();
        n_checks++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL latency_start: txd got %b expected 0", txd);
        end
        for (int c = 0; c < 50; c++) begin
            baud_tick = (c % 4 == 3);
            step();
            n_checks++;
            if ({txd, baud_en, tx_busy, tx_ready, fifo_count} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL single_byte cyc %0d: got %b expected %b", c,
                         {txd, baud_en, tx_busy, tx_ready, fifo_count}, model_vec());
            end
        end
        baud_tick = 1'b0;
        got = '1;
        for (int j = 0; j < 11 && j < tick_bits.size(); j++) got[j] = tick_bits[j];
        n_checks++;
        if (tick_bits.size() != 11 || got !== exp_bits) begin
            n_fail++;
            $display("[TB] FAIL single_byte_bits: got %b (%0d periods) expected %b (11)",
                     got, tick_bits.size(), exp_bits);
        end
        n_checks++;
        if ({txd, baud_en, tx_busy} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL single_byte_idle: got %b expected 100", {txd, baud_en, tx_busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] got;
        logic [7:0]  b;
        int          pushes;
        tick_bits.delete();
        baud_tick = 1'b0;
        tx_valid  = 1'b1;
        pushes    = 0;
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'(8'h11 + i);
            step();
            if (m_pushed) pushes++;
        end
        n_checks++;
        if ({tx_ready, fifo_count} !== {1'b0, 3'd4}) begin
            n_fail++;
            $display("[TB] FAIL b2b_full: got ready=%b count=%0d expected ready=0 count=4",
                     tx_ready, fifo_count);
        end
        for (int c = 0; c < 160; c++) begin
            baud_tick = (c % 2 == 1);
            step();
            if (m_pushed) pushes++;
            if (pushes >= 6) tx_valid = 1'b0;
            n_checks++;
            if ({txd, baud_en, tx_busy, tx_ready, fifo_count} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL b2b cyc %0d: got %b expected %b", c,
                         {txd, baud_en, tx_busy, tx_ready, fifo_count}, model_vec());
            end
        end
        baud_tick = 1'b0;
        tx_valid  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            b   = 8'(8'h11 + k);
            got = 'x;
            for (int j = 0; j < 11; j++)
                if (k * 11 + j < tick_bits.size()) got[j] = tick_bits[k * 11 + j];
            n_checks++;
            if (got !== frame_of(b)) begin
                n_fail++;
                $display("[TB] FAIL b2b_frame %0d: got %b expected %b", k, got, frame_of(b));
            end
        end
    endtask

    task automatic test_idle_ticks();
        for (int c = 0; c < 12; c++) begin
            baud_tick = (c % 2 == 0);
            step();
            n_checks++;
            if ({txd, baud_en, tx_busy, tx_ready, fifo_count} !== 7'b1001000) begin
                n_fail++;
                $display("[TB] FAIL idle_ticks cyc %0d: got %b expected %b", c,
                         {txd, baud_en, tx_busy, tx_ready, fifo_count}, 7'b1001000);
            end
        end
        baud_tick = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [10:0] got;
        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data = 8'(8'hC0 + i);
            step();
        end
        tx_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            baud_tick = 1'b1; step();
            baud_tick = 1'b0; step();
        end
        n_checks++;
        if ({tx_busy, fifo_count} !== {1'b1, 3'd2}) begin
            n_fail++;
            $display("[TB] FAIL midframe_pre: got busy=%b count=%0d expected busy=1 count=2",
                     tx_busy, fifo_count);
        end
        rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h77; baud_tick = 1'b1;
        step();
        n_checks++;
        if ({txd, baud_en, tx_busy, tx_ready, fifo_count} !== 7'b1001000) begin
            n_fail++;
            $display("[TB] FAIL midframe_reset: got %b expected %b",
                     {txd, baud_en, tx_busy, tx_ready, fifo_count}, 7'b1001000);
        end
        rst = 1'b0; tx_valid = 1'b0; baud_tick = 1'b0;
        tick_bits.delete();
        tx_valid = 1'b1; tx_data = 8'h3C;
        step();
        tx_valid = 1'b0;
        step();
        for (int c = 0; c < 30; c++) begin
            baud_tick = (c % 2 == 1);
            step();
            n_checks++;
            if ({txd, baud_en, tx_busy, tx_ready, fifo_count} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL after_reset cyc %0d: got %b expected %b", c,
                         {txd, baud_en, tx_busy, tx_ready, fifo_count}, model_vec());
            end
        end
        baud_tick = 1'b0;
        got = 'x;
        for (int j = 0; j < 11 && j < tick_bits.size(); j++) got[j] = tick_bits[j];
        n_checks++;
        if (got !== frame_of(8'h3C)) begin
            n_fail++;
            $display("[TB] FAIL after_reset_frame: got %b expected %b", got, frame_of(8'h3C));
        end
    endtask

    task automatic test_wrap();
        logic [10:0] got;
        int          nxt;
        tick_bits.delete();
        nxt      = 0;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        for (int c = 0; c < 300; c++) begin
            baud_tick = (c % 2 == 1);
            step();
            if (m_pushed) begin
                nxt++;
                if (nxt >= 12) tx_valid = 1'b0;
                else tx_data = 8'(nxt);
            end
            n_checks++;
            if ({txd, baud_en, tx_busy, tx_ready, fifo_count} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL wrap cyc %0d: got %b expected %b", c,
                         {txd, baud_en, tx_busy, tx_ready, fifo_count}, model_vec());
            end
        end
        baud_tick = 1'b0;
        tx_valid  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            got = 'x;
            for (int j = 0; j < 11; j++)
                if (k * 11 + j < tick_bits.size()) got[j] = tick_bits[k * 11 + j];
            n_checks++;
            if (got !== frame_of(8'(k))) begin
                n_fail++;
                $display("[TB] FAIL wrap_frame %0d: got %b expected %b", k, got, frame_of(8'(k)));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst       = ($urandom_range(0, 149) == 0);
            tx_valid  = ($urandom_range(0, 1) == 1);
            tx_data   = 8'($urandom_range(0, 255));
            baud_tick = ($urandom_range(0, 2) == 0);
            step();
            n_checks++;
            if ({txd, baud_en, tx_busy, tx_ready, fifo_count} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL random cyc %0d: got %b expected %b", c,
                         {txd, baud_en, tx_busy, tx_ready, fifo_count}, model_vec());
            end
        end
        rst = 1'b1; tx_valid = 1'b0; baud_tick = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    // Baud generator for 25 MHz / 115200: one tick every 217 enabled cycles.
    task automatic test_tick_integration();
        int  cnt    = 0;
        int  low    = 0;
        int  busy_c = 0;
        bit  seen   = 1'b0;
        bit  done   = 1'b0;
        bit  en_now;
        tx_valid = 1'b1; tx_data = 8'hFF;
        step();
        tx_valid = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            en_now    = baud_en;
            baud_tick = en_now && (cnt == 216);
            step();
            cnt = (!en_now || cnt == 216) ? 0 : cnt + 1;
            if (txd === 1'b0) low++;
            if (tx_busy === 1'b1) begin
                busy_c++;
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        baud_tick = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL tickgen_timeout: frame still busy after %0d cycles, expected end", busy_c);
        end
        n_checks++;
        if (low < 216 || low > 218) begin
            n_fail++;
            $display("[TB] FAIL tickgen_start_bit: got %0d cycles expected 217+-1", low);
        end
        n_checks++;
        if (busy_c < 2376 || busy_c > 2398) begin
            n_fail++;
            $display("[TB] FAIL tickgen_frame: got %0d cycles expected 2387+-11", busy_c);
        end
    endtask

    initial begin
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        baud_tick = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_idle_ticks();
        test_reset_midframe();
        test_wrap();
        test_random();
        test_tick_integration();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
